// File: rtl/dense_serial_mac_pkg.sv
// rtl/dense_serial_mac_pkg.sv - shared state encoding and fixed-point helpers for the serial dense MAC
package dense_serial_mac_pkg;

    localparam int FX_WORD_MAX = 32;
    localparam int FX_PROD_MAX = 2 * FX_WORD_MAX;

    typedef enum logic [1:0] {
        ACCEPT,
        DRAIN,
        BIAS,
        HOLD
    } dense_serial_state_t;

    // Caller keeps the low WIDTH bits, i.e. bits [WIDTH+nfrac-1:nfrac] of the product.
    function automatic logic signed [FX_PROD_MAX-1:0] fx_trunc_prod(
        input logic signed [FX_PROD_MAX-1:0] prod,
        input int                            nfrac
    );
        return prod >>> nfrac;
    endfunction

endpackage

// File: rtl/dense_serial_mac_if.sv
// rtl/dense_serial_mac_if.sv - element input stream and result output handshake bundle
interface dense_serial_mac_if #(
    parameter int WIDTH       = 17,
    parameter int OUTPUT_SIZE = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_data [OUTPUT_SIZE];

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dense_serial_mac_col.sv
// rtl/dense_serial_mac_col.sv - one output column: product register, truncation and accumulator
module dense_serial_mac_col
    import dense_serial_mac_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int NFRAC = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    prod_load,
    input  logic                    acc_en,
    input  logic                    acc_clr,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] w,
    output logic signed [WIDTH-1:0] acc
);

    logic signed [2*WIDTH-1:0]     prod;
    logic signed [FX_PROD_MAX-1:0] trunc_full;
    logic signed [WIDTH-1:0]       prod_fx;
    logic                          unused_trunc;

    always_comb begin
        trunc_full = fx_trunc_prod(FX_PROD_MAX'(prod), NFRAC);
        prod_fx    = trunc_full[WIDTH-1:0];
    end

    assign unused_trunc = ^trunc_full[FX_PROD_MAX-1:WIDTH];

    // Sum wraps modulo 2^WIDTH; no rounding or saturation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod <= '0;
            acc  <= '0;
        end else begin
            if (prod_load) begin
                prod <= (2*WIDTH)'(x) * (2*WIDTH)'(w);
            end
            if (acc_clr) begin
                acc <= '0;
            end else if (acc_en) begin
                acc <= acc + prod_fx;
            end
        end
    end

endmodule

// File: rtl/dense_serial_mac.sv
// rtl/dense_serial_mac.sv - serial-input dense layer: one element per beat, parallel biased result
module dense_serial_mac
    import dense_serial_mac_pkg::*;
#(
    parameter int WIDTH       = 17,
    parameter int NFRAC       = 10,
    parameter int INPUT_SIZE  = 32,
    parameter int OUTPUT_SIZE = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    dense_serial_mac_if.slave       bus,
    input  logic signed [WIDTH-1:0] weights [INPUT_SIZE*OUTPUT_SIZE],
    input  logic signed [WIDTH-1:0] bias    [OUTPUT_SIZE],
    output logic                    err_last
);

    localparam int               CNT_W    = $clog2(INPUT_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INPUT_SIZE - 1);

    dense_serial_state_t state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                err_q, err_d;
    logic                prod_vld_q;
    logic                accept;
    logic                last_elem;
    logic                acc_clr;
    logic                load_out;

    logic signed [WIDTH-1:0] w_sel  [OUTPUT_SIZE];
    logic signed [WIDTH-1:0] acc    [OUTPUT_SIZE];
    logic signed [WIDTH-1:0] out_q  [OUTPUT_SIZE];

    assign accept    = bus.in_valid && in_ready_q;
    assign last_elem = (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        acc_clr     = 1'b0;
        load_out    = 1'b0;

        // cnt alone defines framing; in_last is only compared against it.
        if (accept && (bus.in_last != last_elem)) begin
            err_d = 1'b1;
        end

        case (state_q)
            ACCEPT: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    if (last_elem) begin
                        cnt_d      = '0;
                        in_ready_d = 1'b0;
                        state_d    = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                state_d = BIAS;
            end
            BIAS: begin
                load_out    = 1'b1;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    acc_clr     = 1'b1;
                    in_ready_d  = 1'b1;
                    state_d     = ACCEPT;
                end
            end
            default: begin
                state_d = ACCEPT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ACCEPT;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            prod_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            prod_vld_q  <= accept;
        end
    end

    // Row of the weight matrix addressed by the current element index.
    always_comb begin
        for (int c = 0; c < OUTPUT_SIZE; c++) begin
            w_sel[c] = '0;
        end
        for (int r = 0; r < INPUT_SIZE; r++) begin
            if (cnt_q == CNT_W'(r)) begin
                for (int c = 0; c < OUTPUT_SIZE; c++) begin
                    w_sel[c] = weights[r*OUTPUT_SIZE + c];
                end
            end
        end
    end

    for (genvar c = 0; c < OUTPUT_SIZE; c++) begin : g_col
        dense_serial_mac_col #(
            .WIDTH (WIDTH),
            .NFRAC (NFRAC)
        ) u_col (
            .clk       (clk),
            .reset     (reset),
            .prod_load (accept),
            .acc_en    (prod_vld_q),
            .acc_clr   (acc_clr),
            .x         (bus.in_data),
            .w         (w_sel[c]),
            .acc       (acc[c])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < OUTPUT_SIZE; c++) begin
                out_q[c] <= '0;
            end
        end else if (load_out) begin
            for (int c = 0; c < OUTPUT_SIZE; c++) begin
                out_q[c] <= acc[c] + bias[c];
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_q;
    assign err_last      = err_q;

endmodule

// File: tb/tb_dense_serial_mac.sv
// tb/tb_dense_serial_mac.sv - randomized self-checking bench for dense_serial_mac
module tb_dense_serial_mac;

    localparam int AW = 8;
    localparam int AN = 0;
    localparam int AI = 7;
    localparam int AO = 5;
    localparam int BW = 8;
    localparam int BN = 4;
    localparam int BI = 2;
    localparam int BO = 1;
    localparam int TMO = 100;

    localparam int BASIC_W [AI*AO] = '{1,2,3,4,5, 3,4,5,6,7, 5,6,7,8,9, 7,8,9,0,1,
                                       9,0,1,2,3, 1,2,3,4,5, 3,4,5,6,7};
    localparam int BASIC_X [AI]    = '{-1, 2, -3, 4, -5, 6, -7};
    localparam int BASIC_EXP [AO]  = '{-42, 4, 0, -44, -48};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dense_serial_mac_if #(.WIDTH(AW), .OUTPUT_SIZE(AO)) ifa ();
    dense_serial_mac_if #(.WIDTH(BW), .OUTPUT_SIZE(BO)) ifb ();

    logic signed [AW-1:0] a_w [AI*AO];
    logic signed [AW-1:0] a_b [AO];
    logic signed [AW-1:0] a_x [AI];
    logic signed [BW-1:0] b_w [BI*BO];
    logic signed [BW-1:0] b_b [BO];
    logic signed [BW-1:0] b_x [BI];
    logic                 err_a, err_b;

    int checks   = 0;
    int failures = 0;
    logic signed [AW-1:0] res_a [AO];
    logic signed [BW-1:0] res_b;
    bit res_to, drv_to;

    dense_serial_mac #(.WIDTH(AW), .NFRAC(AN), .INPUT_SIZE(AI), .OUTPUT_SIZE(AO)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa), .weights(a_w), .bias(a_b), .err_last(err_a)
    );

    dense_serial_mac #(.WIDTH(BW), .NFRAC(BN), .INPUT_SIZE(BI), .OUTPUT_SIZE(BO)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb), .weights(b_w), .bias(b_b), .err_last(err_b)
    );

    function automatic int wrapw(input longint v, input int w);
        longint m;
        m = longint'(1) << w;
        v = v % m;
        if (v < 0) v += m;
        if (v >= m / 2) v -= m;
        return int'(v);
    endfunction

    // Dot product with per-product floor truncation, then bias, wrapped to the word width.
    function automatic int ref_a(input int col);
        longint s = 0;
        for (int i = 0; i < AI; i++) s += (longint'(a_x[i]) * longint'(a_w[i*AO + col])) >>> AN;
        s += longint'(a_b[col]);
        return wrapw(s, AW);
    endfunction

    function automatic int ref_b();
        longint s = 0;
        for (int i = 0; i < BI; i++) s += (longint'(b_x[i]) * longint'(b_w[i*BO])) >>> BN;
        s += longint'(b_b[0]);
        return wrapw(s, BW);
    endfunction

    task automatic load_basic_a();
        for (int k = 0; k < AI*AO; k++) a_w[k] = AW'(BASIC_W[k]);
        for (int i = 0; i < AI; i++) a_x[i] = AW'(BASIC_X[i]);
        for (int c = 0; c < AO; c++) a_b[c] = '0;
    endtask

    task automatic rand_stim_a();
        for (int k = 0; k < AI*AO; k++) a_w[k] = AW'($urandom);
        for (int c = 0; c < AO; c++) a_b[c] = AW'($urandom);
        for (int i = 0; i < AI; i++) a_x[i] = AW'($urandom);
    endtask

    task automatic drive_vec_a(input int last_pos, input int max_gap);
        int n;
        drv_to = 1'b0;
        for (int i = 0; i < AI; i++) begin
            int g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            ifa.in_valid = 1'b0;
            ifa.in_data  = AW'($urandom);
            repeat (g) begin @(posedge clk); #1; end
            ifa.in_valid = 1'b1;
            ifa.in_data  = a_x[i];
            ifa.in_last  = (i == last_pos);
            n = 0;
            while (ifa.in_ready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
            if (n >= TMO) drv_to = 1'b1;
            @(posedge clk); #1;
        end
        ifa.in_valid = 1'b0;
        ifa.in_last  = 1'b0;
    endtask

    task automatic collect_a(input int hold);
        int n = 0;
        ifa.out_ready = 1'b0;
        while (ifa.out_valid !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
        res_to = (n >= TMO);
        for (int c = 0; c < AO; c++) res_a[c] = ifa.out_data[c];
        repeat (hold) begin @(posedge clk); #1; end
        ifa.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drive_collect_b();
        int n;
        drv_to = 1'b0;
        ifb.out_ready = 1'b0;
        for (int i = 0; i < BI; i++) begin
            ifb.in_valid = 1'b1;
            ifb.in_data  = b_x[i];
            ifb.in_last  = (i == BI - 1);
            n = 0;
            while (ifb.in_ready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
            if (n >= TMO) drv_to = 1'b1;
            @(posedge clk); #1;
        end
        ifb.in_valid = 1'b0;
        ifb.in_last  = 1'b0;
        n = 0;
        while (ifb.out_valid !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
        res_to = (n >= TMO);
        res_b  = ifb.out_data[0];
        ifb.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++; if (ifa.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", ifa.in_ready); end
        checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", ifa.out_valid); end
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL rst_err_last got=%b exp=0", err_a); end
        for (int c = 0; c < AO; c++) begin
            checks++; if (ifa.out_data[c] !== '0) begin failures++; $display("FAIL rst_out_data col%0d got=%0d exp=0", c, ifa.out_data[c]); end
        end
        reset = 1'b1;
        #1;
        checks++; if (ifa.in_ready !== 1'b0) begin failures++; $display("FAIL rst_release_early got=%b exp=0", ifa.in_ready); end
        @(posedge clk); #1;
        checks++; if (ifa.in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_edge got=%b exp=1", ifa.in_ready); end
        checks++; if (ifb.in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_edge_b got=%b exp=1", ifb.in_ready); end
    endtask

    task automatic test_basic();
        load_basic_a();
        ifa.out_ready = 1'b1;
        for (int i = 0; i < AI; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_data  = a_x[i];
            ifa.in_last  = (i == AI - 1);
            @(posedge clk); #1;
        end
        ifa.in_valid = 1'b0;
        ifa.in_last  = 1'b0;
        checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_e0 got=%b exp=0", ifa.out_valid); end
        checks++; if (ifa.in_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_e0 got=%b exp=0", ifa.in_ready); end
        @(posedge clk); #1;
        checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_e1 got=%b exp=0", ifa.out_valid); end
        @(posedge clk); #1;
        checks++; if (ifa.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid_e2 got=%b exp=1", ifa.out_valid); end
        checks++; if (ifa.in_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_e2 got=%b exp=0", ifa.in_ready); end
        for (int c = 0; c < AO; c++) begin
            checks++;
            if (ifa.out_data[c] !== AW'(BASIC_EXP[c])) begin
                failures++; $display("FAIL basic_data col%0d got=%0d exp=%0d", c, ifa.out_data[c], BASIC_EXP[c]);
            end
        end
        @(posedge clk); #1;
        checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_e3 got=%b exp=0", ifa.out_valid); end
        checks++; if (ifa.in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_e3 got=%b exp=1", ifa.in_ready); end
    endtask

    task automatic test_fixed_point();
        logic signed [BW-1:0] e;
        b_w[0] = BW'(8);  b_w[1] = BW'($urandom);
        b_x[0] = BW'(24); b_x[1] = '0;
        b_b[0] = BW'(16);
        drive_collect_b();
        checks++; if ({drv_to, res_to} !== 2'b00) begin failures++; $display("FAIL fx_timeout got=%b%b exp=00", drv_to, res_to); end
        checks++; if (res_b !== BW'(28)) begin failures++; $display("FAIL fx_basic got=%0d exp=28", res_b); end
        b_w[0] = BW'(1); b_x[0] = BW'(-1); b_b[0] = '0;
        drive_collect_b();
        checks++; if (res_b !== BW'(-1)) begin failures++; $display("FAIL fx_floor got=%0d exp=-1", res_b); end
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < BI; k++) begin b_w[k] = BW'($urandom); b_x[k] = BW'($urandom); end
            b_b[0] = BW'($urandom);
            e = BW'(ref_b());
            drive_collect_b();
            checks++; if (res_b !== e) begin failures++; $display("FAIL fx_rand v%0d got=%0d exp=%0d", v, res_b, e); end
        end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < AI*AO; k++) a_w[k] = '0;
        for (int c = 0; c < AO; c++) a_b[c] = '0;
        for (int i = 0; i < AI; i++) a_x[i] = '0;
        a_x[0] = AW'(100); a_w[0] = AW'(2);
        drive_vec_a(AI - 1, 0); collect_a(0);
        checks++; if (res_a[0] !== AW'(-56)) begin failures++; $display("FAIL wrap_prod got=%0d exp=-56", res_a[0]); end
        checks++; if (res_a[1] !== '0) begin failures++; $display("FAIL wrap_other got=%0d exp=0", res_a[1]); end
        a_x[0] = '0; a_b[0] = AW'(127);
        drive_vec_a(AI - 1, 0); collect_a(0);
        checks++; if (res_a[0] !== AW'(127)) begin failures++; $display("FAIL wrap_bias got=%0d exp=127", res_a[0]); end
        a_x[0] = AW'(1); a_w[0] = AW'(1);
        drive_vec_a(AI - 1, 0); collect_a(0);
        checks++; if (res_a[0] !== AW'(-128)) begin failures++; $display("FAIL wrap_bias_prod got=%0d exp=-128", res_a[0]); end
    endtask

    task automatic test_backpressure();
        logic signed [AW-1:0] e [AO];
        int n = 0;
        rand_stim_a();
        for (int c = 0; c < AO; c++) e[c] = AW'(ref_a(c));
        drive_vec_a(AI - 1, 0);
        ifa.out_ready = 1'b0;
        while (ifa.out_valid !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
        checks++; if (n >= TMO) begin failures++; $display("FAIL bp_timeout got=%0d exp<%0d", n, TMO); end
        for (int t = 0; t < 20; t++) begin
            ifa.in_valid = 1'($urandom);
            ifa.in_data  = AW'($urandom);
            @(posedge clk); #1;
            checks++; if (ifa.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready t%0d got=%b exp=0", t, ifa.in_ready); end
            checks++; if (ifa.out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid t%0d got=%b exp=1", t, ifa.out_valid); end
        end
        for (int c = 0; c < AO; c++) begin
            checks++; if (ifa.out_data[c] !== e[c]) begin failures++; $display("FAIL bp_hold_data col%0d got=%0d exp=%0d", c, ifa.out_data[c], e[c]); end
        end
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        ifa.out_ready = 1'b0;
        checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", ifa.out_valid); end
        checks++; if (ifa.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", ifa.in_ready); end
        rand_stim_a();
        for (int c = 0; c < AO; c++) e[c] = AW'(ref_a(c));
        drive_vec_a(AI - 1, 0); collect_a(0);
        for (int c = 0; c < AO; c++) begin
            checks++; if (res_a[c] !== e[c]) begin failures++; $display("FAIL bp_next col%0d got=%0d exp=%0d", c, res_a[c], e[c]); end
        end
    endtask

    task automatic test_gaps_framing();
        logic signed [AW-1:0] e;
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL frame_pre got=%b exp=0", err_a); end
        for (int v = 0; v < 3; v++) begin
            rand_stim_a();
            drive_vec_a((v == 0) ? 2 : AI - 1, 3);
            collect_a(int'($urandom_range(3, 0)));
            checks++; if ({drv_to, res_to} !== 2'b00) begin failures++; $display("FAIL frame_timeout v%0d got=%b%b exp=00", v, drv_to, res_to); end
            for (int c = 0; c < AO; c++) begin
                e = AW'(ref_a(c));
                checks++; if (res_a[c] !== e) begin failures++; $display("FAIL frame_data v%0d col%0d got=%0d exp=%0d", v, c, res_a[c], e); end
            end
            checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL frame_err v%0d got=%b exp=1", v, err_a); end
        end
    endtask

    task automatic test_back_to_back();
        logic signed [AW-1:0] e;
        for (int v = 0; v < 5; v++) begin
            rand_stim_a();
            drive_vec_a(AI - 1, 2);
            collect_a(int'($urandom_range(3, 0)));
            checks++; if ({drv_to, res_to} !== 2'b00) begin failures++; $display("FAIL b2b_timeout v%0d got=%b%b exp=00", v, drv_to, res_to); end
            for (int c = 0; c < AO; c++) begin
                e = AW'(ref_a(c));
                checks++; if (res_a[c] !== e) begin failures++; $display("FAIL b2b_data v%0d col%0d got=%0d exp=%0d", v, c, res_a[c], e); end
            end
        end
    endtask

    task automatic test_reset_mid_vector();
        load_basic_a();
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_data  = a_x[AI - 1 - i];
            ifa.in_last  = 1'b0;
            @(posedge clk); #1;
        end
        ifa.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (ifa.in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0", ifa.in_ready); end
        checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", ifa.out_valid); end
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL mid_rst_err got=%b exp=0", err_a); end
        for (int c = 0; c < AO; c++) begin
            checks++; if (ifa.out_data[c] !== '0) begin failures++; $display("FAIL mid_rst_data col%0d got=%0d exp=0", c, ifa.out_data[c]); end
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++; if (ifa.in_ready !== 1'b0) begin failures++; $display("FAIL mid_release_early got=%b exp=0", ifa.in_ready); end
        @(posedge clk); #1;
        checks++; if (ifa.in_ready !== 1'b1) begin failures++; $display("FAIL mid_release_edge got=%b exp=1", ifa.in_ready); end
        drive_vec_a(AI - 1, 0); collect_a(0);
        for (int c = 0; c < AO; c++) begin
            checks++;
            if (res_a[c] !== AW'(BASIC_EXP[c])) begin
                failures++; $display("FAIL mid_golden col%0d got=%0d exp=%0d", c, res_a[c], BASIC_EXP[c]);
            end
        end
        checks++; if (err_b !== 1'b0) begin failures++; $display("FAIL b_err_last got=%b exp=0", err_b); end
    endtask

    initial begin
        reset = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_last = 1'b0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_last = 1'b0; ifb.out_ready = 1'b1;
        for (int k = 0; k < AI*AO; k++) a_w[k] = '0;
        for (int c = 0; c < AO; c++) a_b[c] = '0;
        for (int i = 0; i < AI; i++) a_x[i] = '0;
        for (int k = 0; k < BI*BO; k++) b_w[k] = '0;
        b_b[0] = '0;
        for (int i = 0; i < BI; i++) b_x[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_fixed_point();
        test_wrap();
        test_backpressure();
        test_gaps_framing();
        test_back_to_back();
        test_reset_mid_vector();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dense_serial_mac.md
Name: dense_serial_mac

Overview:
- Folded, resource-shared counterpart of DenseLayer. It consumes the input vector as a serial stream (one element per accepted beat) instead of a parallel array.
- OUTPUT_SIZE multipliers, one per output column, perform multiply-accumulate over INPUT_SIZE beats. Bias is then added and the parallel output vector is presented behind a valid/ready handshake.
- Used where an upstream stage produces one element per cycle, e.g. the RNN hidden-state serializer. Results are bit-exact with DenseLayer for identical weights, bias and inputs.

Parameters:
- WIDTH, 17, signed fixed-point word width of data, weights, bias and outputs.
- NFRAC, 10, number of fractional bits in every word.
- INPUT_SIZE, 32, number of elements per input vector; must be at least 2.
- OUTPUT_SIZE, 4, number of output neurons.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block can accept an element this cycle.
- in_data  in  WIDTH signed  current input element.
- in_last  in  1  marks the final element of a vector (check only).
- weights  in  WIDTH signed x INPUT_SIZE*OUTPUT_SIZE  flattened from shape (INPUT_SIZE, OUTPUT_SIZE); index row*OUTPUT_SIZE+col.
- bias  in  WIDTH signed x OUTPUT_SIZE  per-neuron bias.
- out_valid  out  1  out_data holds a complete result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH signed x OUTPUT_SIZE  result vector, registered.
- err_last  out  1  sticky framing-error flag.

Behaviour:
- Reset (async assert, sync release):
  - state=ACCEPT, cnt=0.
  - in_ready=0, out_valid=0, all out_data=0, err_last=0.
  - Accumulators and product registers cleared.
- in_ready is registered. It rises on the first clk edge after reset release.
- Reset asserted mid-vector or mid-hold discards all partial or pending results.
- An element is accepted on any rising edge with in_valid && in_ready.
- State ACCEPT:
  - in_ready=1.
  - On accept, for every col: prod[col] <= in_data * weights[cnt*OUTPUT_SIZE+col] (full 2*WIDTH signed product), prod_vld <= 1, cnt++.
  - On accept with cnt==INPUT_SIZE-1: in_ready<=0, cnt<=0, go to DRAIN.
- Accumulate stage (every edge where prod_vld=1): acc[col] <= acc[col] + prod[col][WIDTH+NFRAC-1:NFRAC].
  - Truncation is applied per product.
  - The sum wraps modulo 2^WIDTH.
  - No saturation or rounding, identical to DenseLayer.
- State DRAIN: one cycle; the last product is folded into acc. Go to BIAS.
- State BIAS:
  - out_data[col] <= acc[col] + bias[col], WIDTH wrap-around.
  - out_valid <= 1. Go to HOLD.
- State HOLD:
  - out_valid=1, in_ready=0, out_data stable.
  - On out_ready: out_valid<=0, acc cleared, in_ready<=1, go to ACCEPT.
- Latency:
  - out_valid rises exactly 2 edges after the edge that accepted the last element.
  - Minimum vector period is INPUT_SIZE+3 cycles when out_ready is held at 1.
- in_valid during HOLD, DRAIN or BIAS is ignored because in_ready=0; no element is consumed.
- in_valid gaps during ACCEPT stall cnt. Partial accumulation is retained indefinitely.
- in_last check:
  - On accept, if in_last != (cnt==INPUT_SIZE-1), err_last<=1.
  - err_last is sticky until reset.
  - Counting is never resynchronised on in_last; cnt alone defines framing.
- weights and bias must be stable from the first accept of a vector through the BIAS cycle. Changing them mid-vector is unsupported and is not checked.
- out_ready asserted outside HOLD has no effect.

Decomposition:
- Shared package (existing RNN pkg) holds:
  - typedef enum dense_serial_state_t {ACCEPT, DRAIN, BIAS, HOLD}.
  - function fx_trunc_prod(prod, NFRAC) returning bits [WIDTH+NFRAC-1:NFRAC].
  - Both are reused by DenseLayer-equivalence checkers.
- Sub-module dense_serial_mac_col: one column's product register, truncation and accumulator with clear/enable. Instantiated OUTPUT_SIZE times by a generate loop.
- The top level holds the FSM, cnt, the handshake logic and err_last.

Test Plan:
- Basic vector, WIDTH=8, NFRAC=0, INPUT_SIZE=7, OUTPUT_SIZE=5, out_ready=1:
  - Stimulus: inputs -1,2,-3,4,-5,6,-7. Weight rows {1,2,3,4,5},{3,4,5,6,7},{5,6,7,8,9},{7,8,9,0,1},{9,0,1,2,3},{1,2,3,4,5},{3,4,5,6,7}. bias=0.
  - Required: out_data={-42,4,0,-44,-48}, out_valid 2 edges after the 7th accept, in_ready high again after 10 cycles total.
- Fixed-point check, NFRAC=4, INPUT_SIZE=2, OUTPUT_SIZE=1:
  - Stimulus: inputs 24 (1.5) and 0, weight 8 (0.5), bias 16 (1.0).
  - Required: out_data=28 (1.75).
- Wrap, WIDTH=8, NFRAC=0:
  - Stimulus: input 100 with weight 2 (plus a zero element), bias 0.
  - Required: out_data=-56. Then bias 127 on a zero vector -> 127; bias 127 plus product 1 -> -128.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles and pulse in_valid throughout.
  - Required: out_data stable, in_ready=0, no elements consumed. After out_ready pulses, the next vector computes independently with no residue in acc.
- Gaps and framing:
  - Stimulus: random in_valid gaps; in_last asserted on element 3 of 7.
  - Required: correct sums despite gaps; err_last=1 and it persists across later good vectors.
- Reset mid-vector:
  - Stimulus: drop reset after 4 accepts, then release.
  - Required: out_valid=0, out_data=0 and in_ready=0 during reset. in_ready=1 one edge after release. The next full vector gives the golden result with no residue.
